alu_arbiter: RTL and testbench



---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu.sv | 37 +++
 rtl/alu_arb_pick.sv | 47 ++++
 rtl/alu_arbiter.sv | 135 +++++++++++++
 tb/tb_alu_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and default sizes used by the ALU and its arbiter.
package alu_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned MAX_REQ  = 4;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluSll  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluSlt  = 4'd8,
        AluSltu = 4'd9
    } alu_op_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU; undefined opcodes yield a zero result (and therefore a set zero flag).
module alu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o
);

    logic [4:0] shamt;

    assign shamt = b_i[4:0];

    always_comb begin
        result_o = '0;
        case (alu_op_t'(op_i))
            AluAdd:  result_o = a_i + b_i;
            AluSub:  result_o = a_i - b_i;
            AluAnd:  result_o = a_i & b_i;
            AluOr:   result_o = a_i | b_i;
            AluXor:  result_o = a_i ^ b_i;
            AluSll:  result_o = a_i << shamt;
            AluSrl:  result_o = a_i >> shamt;
            AluSra:  result_o = $unsigned($signed(a_i) >>> shamt);
            AluSlt:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            AluSltu: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_arb_pick.sv
// Grant selector: round-robin from ptr_i when ALU_ARBITER_RR_EN is defined, else lowest index wins.
module alu_arb_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IdxW    = 1
) (
    input  logic [NUM_REQ-1:0] eligible_i,
`ifdef ALU_ARBITER_RR_EN
    input  logic [IdxW-1:0]    ptr_i,
`endif
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IdxW-1:0]    idx_o
);

    logic found;

`ifdef ALU_ARBITER_RR_EN
    // Visit candidates in order ptr, ptr+1, ... with wrap; first eligible one wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!found && eligible_i[i] && (i == (int'(ptr_i) + k) % NUM_REQ)) begin
                    found      = 1'b1;
                    grant_o[i] = 1'b1;
                    idx_o      = IdxW'(i);
                end
            end
        end
    end
`else
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && eligible_i[i]) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = IdxW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters with registered per-requester response slots.
// Define ALU_ARBITER_RR_EN for round-robin arbitration; otherwise fixed priority.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned XLEN    = XLEN_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*4-1:0]    req_op,
    input  logic [NUM_REQ*XLEN-1:0] req_a,
    input  logic [NUM_REQ*XLEN-1:0] req_b,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [NUM_REQ*XLEN-1:0] rsp_result,
    output logic [NUM_REQ-1:0]      rsp_zero
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]      eligible;
    logic [NUM_REQ-1:0]      grant;
    logic [IdxW-1:0]         sel_idx;
    logic [3:0]              alu_op;
    logic [XLEN-1:0]         alu_a;
    logic [XLEN-1:0]         alu_b;
    logic [XLEN-1:0]         alu_result;
    logic                    alu_zero;

    logic [NUM_REQ-1:0]      valid_d, valid_q;
    logic [NUM_REQ*XLEN-1:0] result_d, result_q;
    logic [NUM_REQ-1:0]      zero_d, zero_q;

    // A slot may accept a new result only if it is empty or draining this cycle.
    assign eligible = req_valid & (~valid_q | rsp_ready);

`ifdef ALU_ARBITER_RR_EN
    logic [IdxW-1:0] ptr_d, ptr_q;

    alu_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IdxW    (IdxW)
    ) u_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .grant_o    (grant),
        .idx_o      (sel_idx)
    );

    always_comb begin
        ptr_d = ptr_q;
        if (|grant) begin
            ptr_d = (sel_idx == IdxW'(NUM_REQ - 1)) ? '0 : sel_idx + IdxW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    alu_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IdxW    (IdxW)
    ) u_pick (
        .eligible_i (eligible),
        .grant_o    (grant),
        .idx_o      (sel_idx)
    );
`endif

    assign req_ready = reset ? '0 : grant;

    always_comb begin
        alu_op = '0;
        alu_a  = '0;
        alu_b  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == IdxW'(i)) begin
                alu_op = req_op[i*4 +: 4];
                alu_a  = req_a[i*XLEN +: XLEN];
                alu_b  = req_b[i*XLEN +: XLEN];
            end
        end
    end

    alu #(
        .XLEN (XLEN)
    ) u_alu (
        .op_i     (alu_op),
        .a_i      (alu_a),
        .b_i      (alu_b),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    // A grant wins over a drain, so a simultaneous drain and grant reloads the slot.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        zero_d   = zero_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                valid_d[i]               = 1'b1;
                result_d[i*XLEN +: XLEN] = alu_result;
                zero_d[i]                = alu_zero;
            end else if (valid_q[i] && rsp_ready[i]) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            result_q <= '0;
            zero_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign rsp_valid  = valid_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios then randomized traffic against a model.
module tb_alu_arbiter;

    localparam int NR = 2;
    localparam int XL = 32;

    logic            clk;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*4-1:0] req_op;
    logic [NR*XL-1:0] req_a;
    logic [NR*XL-1:0] req_b;
    logic [NR-1:0]   rsp_valid;
    logic [NR-1:0]   rsp_ready;
    logic [NR*XL-1:0] rsp_result;
    logic [NR-1:0]   rsp_zero;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: what each response slot should hold, and the RR pointer.
    bit        mv   [NR];
    bit [31:0] mres [NR];
    bit        mz   [NR];
    int        ptr_m;

    alu_arbiter #(
        .NUM_REQ (NR),
        .XLEN    (XL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] ref_alu(input bit [3:0] op, input bit [31:0] a, input bit [31:0] b);
        int sa;
        int sb;
        int sh;
        sa = a;
        sb = b;
        sh = b % 32;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return sa >>> sh;
            4'd8: return (sa < sb) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [NR-1:0] model_grant();
        logic [NR-1:0] g;
        int j;
        g = '0;
        if (reset) return g;
`ifdef ALU_ARBITER_RR_EN
        for (int k = 0; k < NR; k++) begin
            j = (ptr_m + k) % NR;
            if (g == 0 && req_valid[j] && (!mv[j] || rsp_ready[j])) g[j] = 1'b1;
        end
`else
        for (j = 0; j < NR; j++) begin
            if (g == 0 && req_valid[j] && (!mv[j] || rsp_ready[j])) g[j] = 1'b1;
        end
`endif
        return g;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            mv[i]   = 1'b0;
            mres[i] = '0;
            mz[i]   = 1'b0;
        end
        ptr_m = 0;
    endtask

    task automatic set_req(input int i, input bit v, input bit [3:0] op,
                           input bit [31:0] a, input bit [31:0] b);
        req_valid[i]      = v;
        req_op[i*4 +: 4]  = op;
        req_a[i*XL +: XL] = a;
        req_b[i*XL +: XL] = b;
    endtask

    task automatic check_slots(input string tag);
        for (int i = 0; i < NR; i++) begin
            check($sformatf("%s.rsp_valid%0d", tag, i), 64'(rsp_valid[i]), 64'(mv[i]));
            check($sformatf("%s.rsp_result%0d", tag, i), 64'(rsp_result[i*XL +: XL]),
                  64'(mres[i]));
            check($sformatf("%s.rsp_zero%0d", tag, i), 64'(rsp_zero[i]), 64'(mz[i]));
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the following negedge.
    task automatic step(input string tag);
        logic [NR-1:0] g;
        int sel;
        bit [31:0] r;
        #1;
        g = model_grant();
        check({tag, ".req_ready"}, 64'(req_ready), 64'(g));
        sel = -1;
        r = '0;
        for (int i = 0; i < NR; i++) if (g[i]) sel = i;
        if (sel >= 0) r = ref_alu(req_op[sel*4 +: 4], req_a[sel*XL +: XL], req_b[sel*XL +: XL]);
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (sel == i) begin
                mv[i]   = 1'b1;
                mres[i] = r;
                mz[i]   = (r == 0);
            end else if (mv[i] && rsp_ready[i]) begin
                mv[i] = 1'b0;
            end
        end
        if (sel >= 0) ptr_m = (sel + 1) % NR;
        check_slots(tag);
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '0;
        model_reset();
        #1;
        set_req(0, 1'b1, 4'd0, 32'd1, 32'd1);
        #1;
        check("reset.req_ready", 64'(req_ready), 64'd0);
        check_slots("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);

        // Single requester: ADD then SUB to zero
        rsp_ready = 2'b01;
        set_req(0, 1'b1, 4'd0, 32'd5, 32'd7);
        step("add");
        check("add.result_const", 64'(rsp_result[31:0]), 64'd12);
        set_req(0, 1'b1, 4'd1, 32'd9, 32'd9);
        step("sub");
        check("sub.zero_const", 64'(rsp_zero[0]), 64'd1);
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        step("drain");

        // Contention with both draining every cycle
        rsp_ready = 2'b11;
        set_req(0, 1'b1, 4'd7, 32'h8000_0000, 32'd4);
        set_req(1, 1'b1, 4'd9, 32'd1, 32'hFFFF_FFFF);
        for (int c = 0; c < 4; c++) step($sformatf("cont%0d", c));
        check("cont.sra_const", 64'(rsp_result[31:0]), 64'hF800_0000);
`ifdef ALU_ARBITER_RR_EN
        check("cont.sltu_const", 64'(rsp_result[63:32]), 64'd1);
`endif
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        step("idle");
        step("idle2");

        // Backpressure: held slot blocks new grants and keeps its data
        rsp_ready = 2'b00;
        set_req(0, 1'b1, 4'd4, 32'h1234_5678, 32'h0F0F_0F0F);
        step("bp_load");
        set_req(0, 1'b1, 4'd0, 32'd100, 32'd1);
        step("bp_hold1");
        step("bp_hold2");
        rsp_ready = 2'b01;
        step("bp_reload");
        set_req(0, 1'b1, 4'd15, 32'd3, 32'd4);
        step("undef");
        check("undef.zero_const", 64'(rsp_zero[0]), 64'd1);

        // Asynchronous reset while slot 0 is holding a result
        rsp_ready = 2'b00;
        set_req(0, 1'b1, 4'd0, 32'd40, 32'd2);
        step("pre_rst");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_async.req_ready", 64'(req_ready), 64'd0);
        check_slots("rst_async");
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 2'b11;
        set_req(1, 1'b1, 4'd0, 32'd1, 32'd2);
        step("post_rst");

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                bit [31:0] a;
                a = $urandom;
                set_req(i, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 11)), a,
                        ($urandom_range(0, 7) == 0) ? a : $urandom);
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
